sram_dp: RTL and testbench

SRAM_DP -- requirements
Module: sram_dp

---
 rtl/sram_dp.sv | 151 +++++++++++++++
 tb/tb_sram_dp.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp.sv
// Dual-port block RAM: port A read/write with byte lanes, port B read-only,
// optional output register and a bulk fill engine that owns the array while busy.
module sram_dp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned RAM_SIZE   = 65536,
   parameter string       INIT_FILE  = "grass.mem",
   parameter int unsigned OUT_REG    = 0,
   parameter int unsigned WRITE_MODE = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      a_en,
   input  logic                      a_we,
   input  logic [DATA_WIDTH/8-1:0]   a_be,
   input  logic [ADDR_WIDTH-1:0]     a_addr,
   input  logic [DATA_WIDTH-1:0]     a_din,
   output logic [DATA_WIDTH-1:0]     a_dout,
   output logic                      a_valid,
   input  logic                      b_en,
   input  logic [ADDR_WIDTH-1:0]     b_addr,
   output logic [DATA_WIDTH-1:0]     b_dout,
   output logic                      b_valid,
   input  logic                      fill_start,
   input  logic [DATA_WIDTH-1:0]     fill_value,
   output logic                      fill_busy,
   output logic                      fill_done
);

   localparam int unsigned NB    = DATA_WIDTH / 8;
   localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_state_e;

   logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

   fill_state_e           state_q;
   logic [IDX_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] fill_val_q;
   logic                  fill_busy_q, fill_done_q;

   logic                  a_v1_q, a_v1_d, a_v2_q, a_v2_d;
   logic [DATA_WIDTH-1:0] a_d1_q, a_d1_d, a_d2_q, a_d2_d;
   logic                  b_v1_q, b_v1_d, b_v2_q, b_v2_d;
   logic [DATA_WIDTH-1:0] b_d1_q, b_d1_d, b_d2_q, b_d2_d;

   logic                  a_acc_c, a_in_rng_c, b_in_rng_c, a_wr_c, fill_wr_c;
   logic [IDX_W-1:0]      a_idx_c, b_idx_c;
   logic [DATA_WIDTH-1:0] a_old_c, a_merged_c, a_rdata_c, b_rdata_c;

   // Access decode, read data selection and pipeline next-state.
   always_comb begin
      a_acc_c    = a_en && !fill_busy_q && !reset;
      a_in_rng_c = 32'(a_addr) < RAM_SIZE;
      b_in_rng_c = 32'(b_addr) < RAM_SIZE;
      a_idx_c    = IDX_W'(a_addr);
      b_idx_c    = IDX_W'(b_addr);
      a_wr_c     = a_acc_c && a_we && a_in_rng_c;
      fill_wr_c  = (state_q == ST_FILL) && !reset;

      a_old_c    = a_in_rng_c ? mem[a_idx_c] : '0;
      b_rdata_c  = b_in_rng_c ? mem[b_idx_c] : '0;
      a_merged_c = a_old_c;
      for (int i = 0; i < int'(NB); i++) begin
         if (a_be[i]) a_merged_c[i*8 +: 8] = a_din[i*8 +: 8];
      end
      if (a_we && (WRITE_MODE == 0) && a_in_rng_c) a_rdata_c = a_merged_c;
      else                                          a_rdata_c = a_old_c;

      a_v1_d = a_acc_c;
      a_d1_d = a_acc_c ? a_rdata_c : a_d1_q;
      a_v2_d = a_v1_q;
      a_d2_d = a_v1_q ? a_d1_q : a_d2_q;
      b_v1_d = b_en;
      b_d1_d = b_en ? b_rdata_c : b_d1_q;
      b_v2_d = b_v1_q;
      b_d2_d = b_v1_q ? b_d1_q : b_d2_q;
   end

   // Array write: fill engine and port A never overlap since A is dropped while busy.
   always_ff @(posedge clk) begin
      if (fill_wr_c) begin
         mem[cnt_q] <= fill_val_q;
      end else if (a_wr_c) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (a_be[i]) mem[a_idx_c][i*8 +: 8] <= a_din[i*8 +: 8];
         end
      end
   end

   // Read pipelines for both ports; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_v1_q <= 1'b0;  a_d1_q <= '0;  a_v2_q <= 1'b0;  a_d2_q <= '0;
         b_v1_q <= 1'b0;  b_d1_q <= '0;  b_v2_q <= 1'b0;  b_d2_q <= '0;
      end else begin
         a_v1_q <= a_v1_d;  a_d1_q <= a_d1_d;  a_v2_q <= a_v2_d;  a_d2_q <= a_d2_d;
         b_v1_q <= b_v1_d;  b_d1_q <= b_d1_d;  b_v2_q <= b_v2_d;  b_d2_q <= b_d2_d;
      end
   end

   // Fill sequencer: one word per busy cycle, then a single done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         fill_val_q  <= '0;
         fill_busy_q <= 1'b0;
         fill_done_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               fill_done_q <= 1'b0;
               if (fill_start) begin
                  state_q     <= ST_FILL;
                  cnt_q       <= '0;
                  fill_val_q  <= fill_value;
                  fill_busy_q <= 1'b1;
               end
            end
            ST_FILL: begin
               if (32'(cnt_q) == RAM_SIZE - 1) begin
                  state_q     <= ST_DONE;
                  fill_busy_q <= 1'b0;
                  fill_done_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + IDX_W'(1);
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               fill_done_q <= 1'b0;
               cnt_q       <= '0;
            end
            default: begin
               state_q     <= ST_IDLE;
               fill_busy_q <= 1'b0;
               fill_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign a_valid   = (OUT_REG != 0) ? a_v2_q : a_v1_q;
   assign a_dout    = (OUT_REG != 0) ? a_d2_q : a_d1_q;
   assign b_valid   = (OUT_REG != 0) ? b_v2_q : b_v1_q;
   assign b_dout    = (OUT_REG != 0) ? b_d2_q : b_d1_q;
   assign fill_busy = fill_busy_q;
   assign fill_done = fill_done_q;

endmodule

// File: tb/tb_sram_dp.sv
// Directed bench for sram_dp across five parameter sets.
module tb_sram_dp;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // p0: 8-bit, 64K words, write-first, no output register
   logic p0_a_en, p0_a_we, p0_a_valid, p0_b_en, p0_b_valid, p0_fill_start, p0_fill_busy, p0_fill_done;
   logic [0:0] p0_a_be;
   logic [15:0] p0_a_addr, p0_b_addr;
   logic [7:0] p0_a_din, p0_a_dout, p0_b_dout, p0_fill_value;
   // p1: 16-bit, read-first
   logic p1_a_en, p1_a_we, p1_a_valid, p1_b_en, p1_b_valid, p1_fill_start, p1_fill_busy, p1_fill_done;
   logic [1:0] p1_a_be;
   logic [7:0] p1_a_addr, p1_b_addr;
   logic [15:0] p1_a_din, p1_a_dout, p1_b_dout, p1_fill_value;
   // p2: output register
   logic p2_a_en, p2_a_we, p2_a_valid, p2_b_en, p2_b_valid, p2_fill_start, p2_fill_busy, p2_fill_done;
   logic [0:0] p2_a_be;
   logic [7:0] p2_a_addr, p2_b_addr;
   logic [7:0] p2_a_din, p2_a_dout, p2_b_dout, p2_fill_value;
   // p3: 16 words, fill tests
   logic p3_a_en, p3_a_we, p3_a_valid, p3_b_en, p3_b_valid, p3_fill_start, p3_fill_busy, p3_fill_done;
   logic [0:0] p3_a_be;
   logic [3:0] p3_a_addr, p3_b_addr;
   logic [7:0] p3_a_din, p3_a_dout, p3_b_dout, p3_fill_value;
   // p4: 12 words in a 16-entry address space
   logic p4_a_en, p4_a_we, p4_a_valid, p4_b_en, p4_b_valid, p4_fill_start, p4_fill_busy, p4_fill_done;
   logic [0:0] p4_a_be;
   logic [3:0] p4_a_addr, p4_b_addr;
   logic [7:0] p4_a_din, p4_a_dout, p4_b_dout, p4_fill_value;

   sram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_SIZE(65536), .INIT_FILE(""), .OUT_REG(0), .WRITE_MODE(0)) u_p0 (
      .clk(clk), .reset(reset), .a_en(p0_a_en), .a_we(p0_a_we), .a_be(p0_a_be), .a_addr(p0_a_addr),
      .a_din(p0_a_din), .a_dout(p0_a_dout), .a_valid(p0_a_valid), .b_en(p0_b_en), .b_addr(p0_b_addr),
      .b_dout(p0_b_dout), .b_valid(p0_b_valid), .fill_start(p0_fill_start), .fill_value(p0_fill_value),
      .fill_busy(p0_fill_busy), .fill_done(p0_fill_done));

   sram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .RAM_SIZE(256), .INIT_FILE(""), .OUT_REG(0), .WRITE_MODE(1)) u_p1 (
      .clk(clk), .reset(reset), .a_en(p1_a_en), .a_we(p1_a_we), .a_be(p1_a_be), .a_addr(p1_a_addr),
      .a_din(p1_a_din), .a_dout(p1_a_dout), .a_valid(p1_a_valid), .b_en(p1_b_en), .b_addr(p1_b_addr),
      .b_dout(p1_b_dout), .b_valid(p1_b_valid), .fill_start(p1_fill_start), .fill_value(p1_fill_value),
      .fill_busy(p1_fill_busy), .fill_done(p1_fill_done));

   sram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .RAM_SIZE(256), .INIT_FILE(""), .OUT_REG(1), .WRITE_MODE(0)) u_p2 (
      .clk(clk), .reset(reset), .a_en(p2_a_en), .a_we(p2_a_we), .a_be(p2_a_be), .a_addr(p2_a_addr),
      .a_din(p2_a_din), .a_dout(p2_a_dout), .a_valid(p2_a_valid), .b_en(p2_b_en), .b_addr(p2_b_addr),
      .b_dout(p2_b_dout), .b_valid(p2_b_valid), .fill_start(p2_fill_start), .fill_value(p2_fill_value),
      .fill_busy(p2_fill_busy), .fill_done(p2_fill_done));

   sram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_SIZE(16), .INIT_FILE(""), .OUT_REG(0), .WRITE_MODE(0)) u_p3 (
      .clk(clk), .reset(reset), .a_en(p3_a_en), .a_we(p3_a_we), .a_be(p3_a_be), .a_addr(p3_a_addr),
      .a_din(p3_a_din), .a_dout(p3_a_dout), .a_valid(p3_a_valid), .b_en(p3_b_en), .b_addr(p3_b_addr),
      .b_dout(p3_b_dout), .b_valid(p3_b_valid), .fill_start(p3_fill_start), .fill_value(p3_fill_value),
      .fill_busy(p3_fill_busy), .fill_done(p3_fill_done));

   sram_dp #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RAM_SIZE(12), .INIT_FILE(""), .OUT_REG(0), .WRITE_MODE(0)) u_p4 (
      .clk(clk), .reset(reset), .a_en(p4_a_en), .a_we(p4_a_we), .a_be(p4_a_be), .a_addr(p4_a_addr),
      .a_din(p4_a_din), .a_dout(p4_a_dout), .a_valid(p4_a_valid), .b_en(p4_b_en), .b_addr(p4_b_addr),
      .b_dout(p4_b_dout), .b_valid(p4_b_valid), .fill_start(p4_fill_start), .fill_value(p4_fill_value),
      .fill_busy(p4_fill_busy), .fill_done(p4_fill_done));

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_cmp++; if (p0_a_dout !== 8'h00)  begin n_bad++; $display("FAIL rst_p0_a_dout got %h exp 00", p0_a_dout); end
      n_cmp++; if (p0_a_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_p0_a_valid got %b exp 0", p0_a_valid); end
      n_cmp++; if (p0_b_dout !== 8'h00)  begin n_bad++; $display("FAIL rst_p0_b_dout got %h exp 00", p0_b_dout); end
      n_cmp++; if (p0_b_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_p0_b_valid got %b exp 0", p0_b_valid); end
      n_cmp++; if (p2_a_dout !== 8'h00)  begin n_bad++; $display("FAIL rst_p2_a_dout got %h exp 00", p2_a_dout); end
      n_cmp++; if (p2_b_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_p2_b_valid got %b exp 0", p2_b_valid); end
      n_cmp++; if (p3_fill_busy !== 1'b0) begin n_bad++; $display("FAIL rst_p3_busy got %b exp 0", p3_fill_busy); end
      n_cmp++; if (p3_fill_done !== 1'b0) begin n_bad++; $display("FAIL rst_p3_done got %b exp 0", p3_fill_done); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_write_read();
      p0_a_en = 1'b1; p0_a_we = 1'b1; p0_a_be = 1'b1; p0_a_addr = 16'h0010; p0_a_din = 8'hA5;
      tick();
      n_cmp++; if (p0_a_valid !== 1'b1) begin n_bad++; $display("FAIL wr_valid got %b exp 1", p0_a_valid); end
      n_cmp++; if (p0_a_dout !== 8'hA5) begin n_bad++; $display("FAIL wr_first_dout got %h exp a5", p0_a_dout); end
      p0_a_we = 1'b0; p0_b_en = 1'b1; p0_b_addr = 16'h0010;
      tick();
      n_cmp++; if (p0_a_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid got %b exp 1", p0_a_valid); end
      n_cmp++; if (p0_a_dout !== 8'hA5) begin n_bad++; $display("FAIL rd_dout got %h exp a5", p0_a_dout); end
      n_cmp++; if (p0_b_valid !== 1'b1) begin n_bad++; $display("FAIL b_valid got %b exp 1", p0_b_valid); end
      n_cmp++; if (p0_b_dout !== 8'hA5) begin n_bad++; $display("FAIL b_dout got %h exp a5", p0_b_dout); end
      p0_a_en = 1'b0; p0_b_en = 1'b0;
      tick();
      n_cmp++; if (p0_a_valid !== 1'b0) begin n_bad++; $display("FAIL idle_a_valid got %b exp 0", p0_a_valid); end
      n_cmp++; if (p0_b_valid !== 1'b0) begin n_bad++; $display("FAIL idle_b_valid got %b exp 0", p0_b_valid); end
      n_cmp++; if (p0_a_dout !== 8'hA5) begin n_bad++; $display("FAIL hold_a_dout got %h exp a5", p0_a_dout); end
      // zero byte enables: no change, still a valid
      p0_a_en = 1'b1; p0_a_we = 1'b1; p0_a_be = 1'b0; p0_a_din = 8'h3C;
      tick();
      n_cmp++; if (p0_a_valid !== 1'b1) begin n_bad++; $display("FAIL be0_valid got %b exp 1", p0_a_valid); end
      n_cmp++; if (p0_a_dout !== 8'hA5) begin n_bad++; $display("FAIL be0_dout got %h exp a5", p0_a_dout); end
      p0_a_we = 1'b0;
      tick();
      n_cmp++; if (p0_a_dout !== 8'hA5) begin n_bad++; $display("FAIL be0_readback got %h exp a5", p0_a_dout); end
      // top address of a full 2**ADDR_WIDTH array
      p0_a_we = 1'b1; p0_a_be = 1'b1; p0_a_addr = 16'hFFFF; p0_a_din = 8'h5E;
      tick();
      p0_a_we = 1'b0; p0_a_addr = 16'h0010;
      tick();
      p0_a_addr = 16'hFFFF;
      tick();
      n_cmp++; if (p0_a_dout !== 8'h5E) begin n_bad++; $display("FAIL top_addr got %h exp 5e", p0_a_dout); end
      p0_a_en = 1'b0;
      tick();
   endtask

   task automatic test_byte_lanes();
      p1_a_en = 1'b1; p1_a_we = 1'b1; p1_a_be = 2'b11; p1_a_addr = 8'h03; p1_a_din = 16'h1234;
      tick();
      n_cmp++; if (p1_a_valid !== 1'b1) begin n_bad++; $display("FAIL be_full_valid got %b exp 1", p1_a_valid); end
      p1_a_be = 2'b01; p1_a_din = 16'hABCD;
      tick();
      n_cmp++; if (p1_a_dout !== 16'h1234) begin n_bad++; $display("FAIL read_first_dout got %h exp 1234", p1_a_dout); end
      p1_a_we = 1'b0; p1_a_be = 2'b00;
      tick();
      n_cmp++; if (p1_a_dout !== 16'h12CD) begin n_bad++; $display("FAIL lane_merge got %h exp 12cd", p1_a_dout); end
      p1_a_en = 1'b0; p1_b_en = 1'b1; p1_b_addr = 8'h03;
      tick();
      n_cmp++; if (p1_b_dout !== 16'h12CD) begin n_bad++; $display("FAIL lane_merge_b got %h exp 12cd", p1_b_dout); end
      p1_b_en = 1'b0;
      tick();
   endtask

   task automatic test_out_reg();
      p2_a_en = 1'b1; p2_a_we = 1'b1; p2_a_be = 1'b1; p2_a_addr = 8'h05; p2_a_din = 8'h00;
      tick();
      p2_a_din = 8'h77; p2_b_en = 1'b1; p2_b_addr = 8'h05;
      tick();
      n_cmp++; if (p2_b_valid !== 1'b0) begin n_bad++; $display("FAIL oreg_b_early got %b exp 0", p2_b_valid); end
      n_cmp++; if (p2_a_valid !== 1'b1) begin n_bad++; $display("FAIL oreg_a_lat2 got %b exp 1", p2_a_valid); end
      p2_a_en = 1'b0; p2_b_en = 1'b0;
      tick();
      n_cmp++; if (p2_b_valid !== 1'b1) begin n_bad++; $display("FAIL oreg_b_valid got %b exp 1", p2_b_valid); end
      n_cmp++; if (p2_b_dout !== 8'h00) begin n_bad++; $display("FAIL collide_b_old got %h exp 00", p2_b_dout); end
      n_cmp++; if (p2_a_dout !== 8'h77) begin n_bad++; $display("FAIL oreg_a_dout got %h exp 77", p2_a_dout); end
      tick();
      n_cmp++; if (p2_b_valid !== 1'b0) begin n_bad++; $display("FAIL oreg_b_late got %b exp 0", p2_b_valid); end
      n_cmp++; if (p2_a_valid !== 1'b0) begin n_bad++; $display("FAIL oreg_a_late got %b exp 0", p2_a_valid); end
      n_cmp++; if (p2_b_dout !== 8'h00) begin n_bad++; $display("FAIL oreg_b_hold got %h exp 00", p2_b_dout); end
      p2_b_en = 1'b1;
      tick();
      p2_b_en = 1'b0;
      tick();
      n_cmp++; if (p2_b_dout !== 8'h77) begin n_bad++; $display("FAIL oreg_b_new got %h exp 77", p2_b_dout); end
      tick();
   endtask

   task automatic test_inflight_reset();
      p2_a_en = 1'b1; p2_a_we = 1'b0; p2_a_addr = 8'h05;
      tick();
      p2_a_en = 1'b0; reset = 1'b1;
      tick();
      n_cmp++; if (p2_a_valid !== 1'b0) begin n_bad++; $display("FAIL inflight_valid got %b exp 0", p2_a_valid); end
      n_cmp++; if (p2_a_dout !== 8'h00) begin n_bad++; $display("FAIL inflight_dout got %h exp 00", p2_a_dout); end
      reset = 1'b0;
      tick();
      n_cmp++; if (p2_a_valid !== 1'b0) begin n_bad++; $display("FAIL inflight_late got %b exp 0", p2_a_valid); end
   endtask

   task automatic test_fill();
      int busy_cnt, done_cnt, done_at, av_cnt, bv_cnt;
      p3_fill_start = 1'b1; p3_fill_value = 8'h3C;
      p3_a_en = 1'b1; p3_a_we = 1'b1; p3_a_be = 1'b1; p3_a_addr = 4'd2; p3_a_din = 8'h99;
      tick();
      p3_fill_start = 1'b0; p3_a_en = 1'b0;
      n_cmp++; if (p3_a_valid !== 1'b1) begin n_bad++; $display("FAIL start_a_valid got %b exp 1", p3_a_valid); end
      n_cmp++; if (p3_a_dout !== 8'h99) begin n_bad++; $display("FAIL start_a_dout got %h exp 99", p3_a_dout); end
      n_cmp++; if (p3_fill_busy !== 1'b1) begin n_bad++; $display("FAIL start_busy got %b exp 1", p3_fill_busy); end
      busy_cnt = 1; done_cnt = 0; done_at = -1; av_cnt = 0; bv_cnt = 0;
      for (int k = 1; k < 30; k++) begin
         if (k == 2) begin p3_a_en = 1'b1; p3_a_we = 1'b1; p3_a_addr = 4'd7; p3_a_din = 8'hFF; end
         if (k == 6) p3_a_en = 1'b0;
         if (k == 4) begin p3_fill_start = 1'b1; p3_fill_value = 8'hC3; end
         if (k == 5) p3_fill_start = 1'b0;
         if (k == 8) begin p3_b_en = 1'b1; p3_b_addr = 4'd2; end
         if (k == 9) p3_b_en = 1'b0;
         tick();
         if (p3_fill_busy === 1'b1) busy_cnt++;
         if (p3_fill_done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = k; end
         if (p3_a_valid === 1'b1) av_cnt++;
         if (p3_b_valid === 1'b1) bv_cnt++;
      end
      n_cmp++; if (busy_cnt != 16) begin n_bad++; $display("FAIL fill_busy_cycles got %0d exp 16", busy_cnt); end
      n_cmp++; if (done_cnt != 1)  begin n_bad++; $display("FAIL fill_done_pulses got %0d exp 1", done_cnt); end
      n_cmp++; if (done_at != 16)  begin n_bad++; $display("FAIL fill_done_cycle got %0d exp 16", done_at); end
      n_cmp++; if (av_cnt != 0)    begin n_bad++; $display("FAIL fill_a_dropped got %0d exp 0", av_cnt); end
      n_cmp++; if (bv_cnt != 1)    begin n_bad++; $display("FAIL fill_b_served got %0d exp 1", bv_cnt); end
      n_cmp++; if (p3_b_dout !== 8'h3C) begin n_bad++; $display("FAIL fill_b_dout got %h exp 3c", p3_b_dout); end
      p3_a_en = 1'b1; p3_a_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         p3_a_addr = 4'(i);
         tick();
         n_cmp++;
         if (p3_a_dout !== 8'h3C || p3_a_valid !== 1'b1) begin
            n_bad++; $display("FAIL fill_word_%0d got %h/%b exp 3c/1", i, p3_a_dout, p3_a_valid);
         end
      end
      p3_a_en = 1'b0;
      tick();
   endtask

   task automatic test_fill_reset();
      int done_cnt, busy_cnt;
      logic [7:0] exp;
      p3_a_en = 1'b1; p3_a_we = 1'b1; p3_a_be = 1'b1; p3_a_din = 8'h11;
      for (int i = 0; i < 16; i++) begin
         p3_a_addr = 4'(i);
         tick();
      end
      p3_a_en = 1'b0;
      p3_fill_value = 8'h5A; p3_fill_start = 1'b1;
      tick();
      p3_fill_start = 1'b0;
      repeat (5) tick();
      n_cmp++; if (p3_fill_busy !== 1'b1) begin n_bad++; $display("FAIL abort_prebusy got %b exp 1", p3_fill_busy); end
      reset = 1'b1;
      tick();
      n_cmp++; if (p3_fill_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b exp 0", p3_fill_busy); end
      n_cmp++; if (p3_fill_done !== 1'b0) begin n_bad++; $display("FAIL abort_done got %b exp 0", p3_fill_done); end
      reset = 1'b0;
      done_cnt = 0; busy_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (p3_fill_done === 1'b1) done_cnt++;
         if (p3_fill_busy === 1'b1) busy_cnt++;
      end
      n_cmp++; if (done_cnt != 0 || busy_cnt != 0) begin n_bad++; $display("FAIL abort_after got done=%0d busy=%0d exp 0/0", done_cnt, busy_cnt); end
      p3_a_en = 1'b1; p3_a_we = 1'b0;
      for (int i = 0; i < 16; i++) begin
         p3_a_addr = 4'(i);
         exp = (i < 5) ? 8'h5A : 8'h11;
         tick();
         n_cmp++;
         if (p3_a_dout !== exp) begin n_bad++; $display("FAIL abort_word_%0d got %h exp %h", i, p3_a_dout, exp); end
      end
      p3_a_en = 1'b0;
      tick();
   endtask

   task automatic test_out_of_range();
      p4_a_en = 1'b1; p4_a_we = 1'b1; p4_a_be = 1'b1; p4_a_addr = 4'hE; p4_a_din = 8'h55;
      tick();
      n_cmp++; if (p4_a_valid !== 1'b1) begin n_bad++; $display("FAIL oor_wr_valid got %b exp 1", p4_a_valid); end
      p4_a_addr = 4'hB; p4_a_din = 8'h66;
      tick();
      p4_a_we = 1'b0; p4_a_addr = 4'hE;
      tick();
      n_cmp++; if (p4_a_dout !== 8'h00) begin n_bad++; $display("FAIL oor_rd_dout got %h exp 00", p4_a_dout); end
      n_cmp++; if (p4_a_valid !== 1'b1) begin n_bad++; $display("FAIL oor_rd_valid got %b exp 1", p4_a_valid); end
      p4_a_addr = 4'hB;
      tick();
      n_cmp++; if (p4_a_dout !== 8'h66) begin n_bad++; $display("FAIL last_word got %h exp 66", p4_a_dout); end
      p4_a_addr = 4'hC;
      tick();
      n_cmp++; if (p4_a_dout !== 8'h00) begin n_bad++; $display("FAIL first_oor got %h exp 00", p4_a_dout); end
      p4_a_en = 1'b0; p4_b_en = 1'b1; p4_b_addr = 4'hE;
      tick();
      n_cmp++; if (p4_b_dout !== 8'h00 || p4_b_valid !== 1'b1) begin n_bad++; $display("FAIL oor_b got %h/%b exp 00/1", p4_b_dout, p4_b_valid); end
      p4_b_en = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      p0_a_en = 0; p0_a_we = 0; p0_a_be = '0; p0_a_addr = '0; p0_a_din = '0; p0_b_en = 0; p0_b_addr = '0; p0_fill_start = 0; p0_fill_value = '0;
      p1_a_en = 0; p1_a_we = 0; p1_a_be = '0; p1_a_addr = '0; p1_a_din = '0; p1_b_en = 0; p1_b_addr = '0; p1_fill_start = 0; p1_fill_value = '0;
      p2_a_en = 0; p2_a_we = 0; p2_a_be = '0; p2_a_addr = '0; p2_a_din = '0; p2_b_en = 0; p2_b_addr = '0; p2_fill_start = 0; p2_fill_value = '0;
      p3_a_en = 0; p3_a_we = 0; p3_a_be = '0; p3_a_addr = '0; p3_a_din = '0; p3_b_en = 0; p3_b_addr = '0; p3_fill_start = 0; p3_fill_value = '0;
      p4_a_en = 0; p4_a_we = 0; p4_a_be = '0; p4_a_addr = '0; p4_a_din = '0; p4_b_en = 0; p4_b_addr = '0; p4_fill_start = 0; p4_fill_value = '0;
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_reg();
      test_inflight_reset();
      test_fill();
      test_fill_reset();
      test_out_of_range();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
